// File: rtl/ascon_spi_loader.sv
// ascon_spi_loader: SPI mode-0 slave loading key/text/AD registers, state words and start pulses for the ascon core
// Optional: define ASCON_SPI_READBACK_EN to read S_0..S_4_reg back over spi_miso (opcode 100).
// Ports: clk, rst_n (async, active-low); spi_sclk/spi_cs_n/spi_mosi/spi_miso SPI pins;
//   S_0_reg..S_4_reg readback source; reg0/1/2_128b key/text/AD; operation_mode/operation_ready start;
//   state_shift_en/sel/lsb serial state load; frame_err malformed-frame pulse.
module ascon_spi_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int REG_W = 128,
  parameter int STATE_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  input  logic [STATE_W-1:0] S_0_reg,
  input  logic [STATE_W-1:0] S_1_reg,
  input  logic [STATE_W-1:0] S_2_reg,
  input  logic [STATE_W-1:0] S_3_reg,
  input  logic [STATE_W-1:0] S_4_reg,
  output logic [REG_W-1:0]   reg0_128b,
  output logic [REG_W-1:0]   reg1_128b,
  output logic [REG_W-1:0]   reg2_128b,
  output logic [2:0]         operation_mode,
  output logic               operation_ready,
  output logic               state_shift_en,
  output logic [2:0]         state_shift_sel,
  output logic               state_shift_lsb,
  output logic               frame_err
);
  localparam logic [7:0] REG_END = 8'(8 + REG_W);
  localparam logic [7:0] ST_END = 8'(8 + STATE_W);
`ifdef ASCON_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CMD, WREG, WSTATE, START, RSTATE, IGNORE} state_t;
  state_t state, dec;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall, bit_ok;
  logic [7:0] bit_cnt, cmd, nxt_cmd;
  logic [REG_W-1:0] shadow;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cs_fall = ~cs_s & cs_d;
  // a clock edge seen together with the chip-select release belongs to no frame
  assign bit_ok = sclk_rise & ~cs_s;
  assign nxt_cmd = {cmd[6:0], mosi_s};
  always_comb
    dec = nxt_cmd[7:5] == 3'b001 && nxt_cmd[4:2] <= 3'd2 ? WREG :
          nxt_cmd[7:5] == 3'b010 && nxt_cmd[4:2] <= 3'd4 ? WSTATE :
          nxt_cmd[7:5] == 3'b011 ? START :
          RB && nxt_cmd[7:5] == 3'b100 && nxt_cmd[4:2] <= 3'd4 ? RSTATE : IGNORE;
  // cs sync resets low so a reset released mid-frame waits for a fresh cs_n fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      cmd <= '0;
      shadow <= '0;
      reg0_128b <= '0;
      reg1_128b <= '0;
      reg2_128b <= '0;
      operation_mode <= '0;
      operation_ready <= 1'b0;
      state_shift_en <= 1'b0;
      state_shift_sel <= '0;
      state_shift_lsb <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      cs_q <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_s;
      cs_d <= cs_s;
      operation_ready <= 1'b0;
      state_shift_en <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        frame_err <= state == CMD || state == IGNORE ||
                     (state == WREG && bit_cnt != REG_END) ||
                     (state == WSTATE && bit_cnt < ST_END) ||
                     (state == START && bit_cnt != 8'd8);
        if (state == WREG && bit_cnt == REG_END && cmd[4:2] == 3'd0) reg0_128b <= shadow;
        if (state == WREG && bit_cnt == REG_END && cmd[4:2] == 3'd1) reg1_128b <= shadow;
        if (state == WREG && bit_cnt == REG_END && cmd[4:2] == 3'd2) reg2_128b <= shadow;
        if (state == START && bit_cnt == 8'd8) begin
          operation_mode <= cmd[4:2];
          operation_ready <= 1'b1;
        end
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state <= CMD;
          bit_cnt <= '0;
        end
      end else if (bit_ok) begin
        bit_cnt <= bit_cnt == 8'hFF ? bit_cnt : bit_cnt + 8'd1;
        if (state == CMD) begin
          cmd <= nxt_cmd;
          if (bit_cnt == 8'd7) state <= dec;
        end
        if (state == WREG && bit_cnt < REG_END) shadow <= {shadow[REG_W-2:0], mosi_s};
        if (state == WSTATE && bit_cnt < ST_END) begin
          state_shift_en <= 1'b1;
          state_shift_sel <= cmd[4:2];
          state_shift_lsb <= mosi_s;
        end
      end
    end
`ifdef ASCON_SPI_READBACK_EN
  logic [STATE_W-1:0] snap;
  // the fall right after the command byte presents the MSB, so shifting starts one fall later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      snap <= '0;
    else if (state == CMD && bit_ok && bit_cnt == 8'd7 && dec == RSTATE)
      snap <= nxt_cmd[4:2] == 3'd0 ? S_0_reg :
              nxt_cmd[4:2] == 3'd1 ? S_1_reg :
              nxt_cmd[4:2] == 3'd2 ? S_2_reg :
              nxt_cmd[4:2] == 3'd3 ? S_3_reg : S_4_reg;
    else if (state == RSTATE && sclk_fall && bit_cnt > 8'd8)
      snap <= snap << 1;
  assign spi_miso = state == RSTATE && !cs_s && snap[STATE_W-1];
`else
  logic unused;
  assign unused = ^{S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, sclk_fall};
  assign spi_miso = 1'b0;
`endif
endmodule

// File: tb/tb_ascon_spi_loader.sv
// tb_ascon_spi_loader: randomized frame-level check of ascon_spi_loader against a frame-rule model
module tb_ascon_spi_loader;
  localparam int HP = 60;
`ifdef ASCON_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, operation_ready, state_shift_en, state_shift_lsb, frame_err;
  logic [2:0] operation_mode, state_shift_sel;
  logic [127:0] reg0_128b, reg1_128b, reg2_128b;
  logic [63:0] s_reg [5];
  int checks = 0, errors = 0;
  int rdy_cnt = 0, err_cnt = 0;
  bit fb[$];
  bit got_miso[$];
  logic [3:0] got_sh[$];
  logic [127:0] exp_reg [3];
  logic [2:0] exp_mode;

  ascon_spi_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .S_0_reg(s_reg[0]), .S_1_reg(s_reg[1]), .S_2_reg(s_reg[2]),
    .S_3_reg(s_reg[3]), .S_4_reg(s_reg[4]), .reg0_128b(reg0_128b), .reg1_128b(reg1_128b),
    .reg2_128b(reg2_128b), .operation_mode(operation_mode), .operation_ready(operation_ready),
    .state_shift_en(state_shift_en), .state_shift_sel(state_shift_sel),
    .state_shift_lsb(state_shift_lsb), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (state_shift_en) got_sh.push_back({state_shift_sel, state_shift_lsb});
    if (operation_ready) rdy_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_bits(input logic [127:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) fb.push_back(v[i]);
  endtask

  task automatic push_rand(input int w);
    for (int i = 0; i < w; i++) fb.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic spi_bit(input bit b);
    spi_mosi = b;
    #HP;
    got_miso.push_back(spi_miso);
    spi_sclk = 1'b1;
    #HP;
    spi_sclk = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".reg0"}, reg0_128b, '0);
    check({tag, ".reg1"}, reg1_128b, '0);
    check({tag, ".reg2"}, reg2_128b, '0);
    check({tag, ".ctl"}, {operation_mode, operation_ready, state_shift_en, state_shift_sel,
                          state_shift_lsb, frame_err, spi_miso}, '0);
  endtask

  task automatic run_frame(input string tag);
    int n, exp_err, exp_rdy;
    logic [2:0] op, a;
    logic [127:0] v;
    logic [3:0] esh[$];
    bit emiso[$];
    n = fb.size();
    exp_err = 0;
    exp_rdy = 0;
    v = '0;
    @(negedge clk);
    got_sh.delete();
    got_miso.delete();
    rdy_cnt = 0;
    err_cnt = 0;
    spi_cs_n = 1'b0;
    foreach (fb[i]) spi_bit(fb[i]);
    #HP;
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    op = n >= 8 ? {fb[0], fb[1], fb[2]} : 3'd0;
    a = n >= 8 ? {fb[3], fb[4], fb[5]} : 3'd0;
    if (n < 8) exp_err = 1;
    else if (op == 3'd1 && a <= 3'd2) begin
      if (n == 136) begin
        for (int i = 8; i < 136; i++) v = {v[126:0], fb[i]};
        exp_reg[a] = v;
      end else exp_err = 1;
    end else if (op == 3'd2 && a <= 3'd4) begin
      for (int i = 8; i < n && i < 72; i++) esh.push_back({a, fb[i]});
      if (n < 72) exp_err = 1;
    end else if (op == 3'd3) begin
      if (n == 8) begin
        exp_mode = a;
        exp_rdy = 1;
      end else exp_err = 1;
    end else if (op == 3'd4 && a <= 3'd4 && RB) begin
      for (int i = 8; i < n; i++) emiso.push_back(i < 72 ? s_reg[a][71 - i] : 1'b0);
    end else begin
      exp_err = 1;
      if (op == 3'd4) for (int i = 8; i < n; i++) emiso.push_back(1'b0);
    end
    check({tag, ".frame_err"}, err_cnt, exp_err);
    check({tag, ".ready"}, rdy_cnt, exp_rdy);
    check({tag, ".mode"}, operation_mode, exp_mode);
    check({tag, ".reg0"}, reg0_128b, exp_reg[0]);
    check({tag, ".reg1"}, reg1_128b, exp_reg[1]);
    check({tag, ".reg2"}, reg2_128b, exp_reg[2]);
    check({tag, ".shifts"}, got_sh.size(), esh.size());
    for (int i = 0; i < esh.size() && i < got_sh.size(); i++) check({tag, ".shift"}, got_sh[i], esh[i]);
    for (int i = 0; i < emiso.size(); i++) check({tag, ".miso"}, got_miso[8 + i], emiso[i]);
    check({tag, ".miso_idle"}, spi_miso, 1'b0);
    fb.delete();
  endtask

  initial begin
    int kind, len;
    logic [2:0] a;
    logic [7:0] pat;
    logic [63:0] pk;
    for (int i = 0; i < 5; i++) s_reg[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) exp_reg[i] = '0;
    exp_mode = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    push_bits(8'h20, 8);
    push_bits(128'h000102030405060708090A0B0C0D0E0F, 128);
    run_frame("wreg0");
    check("wreg0.value", reg0_128b, 128'h000102030405060708090A0B0C0D0E0F);

    push_bits(8'h28, 8);
    push_rand(100);
    run_frame("wreg2_short");

    push_bits(8'h4C, 8);
    push_bits(64'hA5A5A5A5A5A5A5A5, 64);
    run_frame("wstate3");
    pat = '0;
    for (int i = 0; i < 8; i++) pat = {pat[6:0], got_sh[i][0]};
    check("wstate3.lsb_seq", pat, 8'hA5);
    check("wstate3.sel", got_sh[0][3:1], 3'd3);

    push_bits(8'h64, 8);
    run_frame("start1");
    check("start1.mode_abs", operation_mode, 3'b001);
    push_bits(8'hE0, 8);
    run_frame("bad_op");

    s_reg[1] = 64'hDEADBEEF01234567;
    push_bits(8'h84, 8);
    push_rand(64);
    run_frame("rstate1");
    pk = '0;
    for (int i = 0; i < 64; i++) pk = {pk[62:0], got_miso[8 + i]};
    check("rstate1.word", pk, RB ? 64'hDEADBEEF01234567 : 64'h0);

    push_bits(8'h64, 8);
    push_rand(3);
    run_frame("start_long");
    push_rand(5);
    run_frame("short_cmd");

    @(negedge clk);
    rdy_cnt = 0;
    err_cnt = 0;
    spi_cs_n = 1'b0;
    push_bits(8'h24, 8);
    push_rand(20);
    foreach (fb[i]) spi_bit(fb[i]);
    fb.delete();
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 108; i++) spi_bit(1'($urandom_range(0, 1)));
    #HP;
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset.no_err", err_cnt, 0);
    check("midreset.no_ready", rdy_cnt, 0);
    check("midreset.reg1", reg1_128b, '0);
    for (int i = 0; i < 3; i++) exp_reg[i] = '0;
    exp_mode = '0;

    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 5; i++) s_reg[i] = {$urandom, $urandom};
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          a = 3'($urandom_range(0, 3));
          len = $urandom_range(0, 2) != 0 ? 128 : $urandom_range(120, 140);
          push_bits({3'b001, a, 2'($urandom_range(0, 3))}, 8);
          push_rand(len);
        end
        1: begin
          a = 3'($urandom_range(0, 5));
          len = $urandom_range(0, 1) != 0 ? 64 : $urandom_range(10, 80);
          push_bits({3'b010, a, 2'($urandom_range(0, 3))}, 8);
          push_rand(len);
        end
        2: begin
          a = 3'($urandom_range(0, 7));
          push_bits({3'b011, a, 2'($urandom_range(0, 3))}, 8);
          push_rand($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, 4));
        end
        3: begin
          a = 3'($urandom_range(0, 5));
          push_bits({3'b100, a, 2'($urandom_range(0, 3))}, 8);
          push_rand($urandom_range(64, 70));
        end
        4: begin
          push_bits({3'($urandom_range(5, 7)), 5'($urandom)}, 8);
          push_rand($urandom_range(0, 12));
        end
        default: push_rand($urandom_range(0, 7));
      endcase
      run_frame($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
